// File: rtl/draw_star_square.sv
// rtl/draw_star_square.sv - plots one SIDE x SIDE square for a star grid cell on a VGA adapter.
// Optional macro DRAW_OUTLINE_EN plots only the square's border pixels.
module draw_star_square #(
  parameter int          SIDE     = 4,
  parameter int          X_ORIGIN = 8,
  parameter int          Y_ORIGIN = 8,
  parameter logic [2:0]  COLOUR   = 3'b111
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       goDraw,
  input  logic [2:0] xIn,
  input  logic [2:0] yIn,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       doneDraw
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam logic [2:0] LAST = 3'(SIDE - 1);

  state_t     state, state_next;
  logic [2:0] cx, cy;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic       armed;
  logic       in_range, start, last_px, edge_px;

  assign in_range = (xIn < 3'd6) && (yIn < 3'd6);
  assign start    = (state == IDLE) && goDraw && armed;
  assign last_px  = (cx == LAST) && (cy == LAST);

`ifdef DRAW_OUTLINE_EN
  assign edge_px = (cx == 3'd0) || (cx == LAST) || (cy == 3'd0) || (cy == LAST);
`else
  assign edge_px = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    x          = 8'd0;
    y          = 7'd0;
    colour     = 3'd0;
    plot       = 1'b0;
    doneDraw   = 1'b0;
    case (state)
      IDLE: if (start) state_next = in_range ? DRAW : DONE;
      DRAW: begin
        x      = base_x + {5'd0, cx};
        y      = base_y + {4'd0, cy};
        colour = COLOUR;
        plot   = edge_px;
        if (last_px) state_next = DONE;
      end
      DONE: begin
        doneDraw = 1'b1;
        if (!goDraw) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // armed: a fresh request needs goDraw seen low while idle, so a held goDraw never redraws
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cx     <= 3'd0;
      cy     <= 3'd0;
      base_x <= 8'd0;
      base_y <= 7'd0;
      armed  <= 1'b1;
    end else begin
      if (start)                          armed <= 1'b0;
      else if (state == IDLE && !goDraw)  armed <= 1'b1;

      if (start && in_range) begin
        base_x <= 8'(X_ORIGIN) + 8'(xIn) * 8'(SIDE);
        base_y <= 7'(Y_ORIGIN) + 7'(yIn) * 7'(SIDE);
        cx     <= 3'd0;
        cy     <= 3'd0;
      end else if (state == DRAW) begin
        if (cx == LAST) begin
          cx <= 3'd0;
          cy <= cy + 3'd1;
        end else begin
          cx <= cx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_draw_star_square.sv
// tb/tb_draw_star_square.sv - scoreboard bench for draw_star_square.
// Expected pixels and doneDraw edge numbers are queued at request time and checked by a monitor.
module tb_draw_star_square;

  localparam int         SIDE = 4;
  localparam int         XO   = 8;
  localparam int         YO   = 8;
  localparam logic [2:0] COL  = 3'b111;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       goDraw = 1'b0;
  logic [2:0] xIn = 3'd0;
  logic [2:0] yIn = 3'd0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       doneDraw;

  int checks = 0;
  int errors = 0;
  int ec = 0;
  logic done_prev = 1'b0;

  int pq[$];
  int dq[$];

  draw_star_square #(.SIDE(SIDE), .X_ORIGIN(XO), .Y_ORIGIN(YO), .COLOUR(COL)) dut (
    .clk(clk), .resetn(resetn), .goDraw(goDraw), .xIn(xIn), .yIn(yIn),
    .x(x), .y(y), .colour(colour), .plot(plot), .doneDraw(doneDraw)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every plot pops one expected pixel; every doneDraw rise pops one expected edge number.
  always @(negedge clk) begin
    if (plot) begin
      if (pq.size() == 0) chk("unexpected_plot", 1, 0);
      else begin
        int e;
        e = pq.pop_front();
        chk("pixel", {x, 1'b0, y, colour}, e);
      end
    end
    if (doneDraw && !done_prev) begin
      if (dq.size() == 0) chk("unexpected_done", 1, 0);
      else chk("done_edge", ec, dq.pop_front());
      chk("pixels_left_at_done", pq.size(), 0);
    end
    done_prev = doneDraw;
  end

  task automatic start_req(input int xi, input int yi);
    int bx, by, n;
    goDraw = 1'b0;
    repeat (2) @(negedge clk);
    n = 0;
    if (xi < 6 && yi < 6) begin
      bx = XO + xi * SIDE;
      by = YO + yi * SIDE;
      for (int r = 0; r < SIDE; r++)
        for (int c = 0; c < SIDE; c++) begin
`ifdef DRAW_OUTLINE_EN
          if (r == 0 || c == 0 || r == SIDE - 1 || c == SIDE - 1)
`endif
          pq.push_back({8'(bx + c), 1'b0, 7'(by + r), COL});
        end
      n = SIDE * SIDE;
    end
    // goDraw sampled first at edge k = ec+1; doneDraw rises after edge k+n
    dq.push_back(ec + 1 + n);
    xIn = 3'(xi);
    yIn = 3'(yi);
    goDraw = 1'b1;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!doneDraw && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!doneDraw) chk("done_timeout", 0, 1);
  endtask

  task automatic finish_req();
    wait_done();
    goDraw = 1'b0;
    @(negedge clk);
    chk("done_drop", doneDraw, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_plot", plot, 0);
    chk("rst_done", doneDraw, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_colour", colour, 0);
    resetn = 1'b1;

    start_req(2, 3); finish_req();
    start_req(5, 5); finish_req();
    start_req(6, 0); finish_req();
    start_req(0, 6); finish_req();

    // reset asserted in the 5th DRAW cycle
    start_req(1, 1);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    goDraw = 1'b0;
    @(negedge clk);
    chk("abort_plot", plot, 0);
    chk("abort_done", doneDraw, 0);
    chk("abort_x", x, 0);
    chk("abort_y", y, 0);
    pq.delete();
    dq.delete();
    resetn = 1'b1;
    start_req(0, 0); finish_req();

    // goDraw dropped mid-draw: square completes, DONE lasts one cycle
    start_req(3, 1);
    repeat (3) @(negedge clk);
    goDraw = 1'b0;
    wait_done();
    @(negedge clk);
    chk("short_done", doneDraw, 0);

    // coordinates changed mid-draw are ignored
    start_req(4, 2);
    repeat (2) @(negedge clk);
    xIn = 3'd0;
    yIn = 3'd0;
    finish_req();

    // goDraw held high after completion draws nothing more
    start_req(1, 4);
    wait_done();
    repeat (6) @(negedge clk);
    chk("hold_done", doneDraw, 1);
    chk("hold_plot", plot, 0);
    goDraw = 1'b0;
    @(negedge clk);
    chk("hold_release", doneDraw, 0);
    start_req(1, 4); finish_req();

    repeat (4) @(negedge clk);
    chk("pixels_pending", pq.size(), 0);
    chk("dones_pending", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
